mainfsm_mc: RTL and testbench

Parametrised multicycle control FSM for the ARM-subset processor. It is the next generation of the main decoder FSM and keeps its state flow for data-processing, load/store and branch instructions. It adds three things: a memory ready/request handshake, so fetch and data accesses stall until the memory responds; a multi-cycle multiply execute state with a configurable latency counter; and branch-with-link. It sits in the controller between the instruction decode fields and the datapath mux/enable signals.

---
 rtl/mainfsm_mc_pkg.sv | 34 +++
 rtl/mainfsm_mc_counter.sv | 25 ++
 rtl/mainfsm_mc.sv | 182 ++++++++++++++++++
 tb/tb_mainfsm_mc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mainfsm_mc_pkg.sv
// Shared encodings for the multicycle main FSM: state codes and datapath mux selects.
package mainfsm_mc_pkg;

  typedef logic [3:0] state_t;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_UNKNOWN  = 4'd10;
  localparam logic [3:0] S_MULEX    = 4'd11;
  localparam logic [3:0] S_BLINK    = 4'd12;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_MUL    = 2'b11;

  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCA_ALT   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] SRCB_ZERO  = 2'b11;

endpackage

// File: rtl/mainfsm_mc_counter.sv
// Loadable down-counter that saturates at zero; times the multiply execute state.
module mc_down_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && !zero)
      count <= count - 1'b1;
  end

endmodule

// File: rtl/mainfsm_mc.sv
// Multicycle main control FSM with memory handshake, multi-cycle multiply and branch-with-link.
module mainfsm_mc
  import mainfsm_mc_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = $clog2(MUL_LATENCY + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       IsMul,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemW,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       MulStart,
  output logic       LinkW,
  output logic       Illegal,
  output logic [3:0] StateDbg
);

  state_t           state, state_nxt;
  logic             mul_flag;
  logic             mul_load, mul_dec, mul_zero;
  logic [CNT_W-1:0] mul_cnt;
  logic             unused_funct;

  assign unused_funct = ^Funct[3:1];

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          2'b00:   state_nxt = IsMul ? S_MULEX : (Funct[5] ? S_EXECUTEI : S_EXECUTER);
          2'b01:   state_nxt = S_MEMADR;
          2'b10:   state_nxt = Funct[4] ? S_BLINK : S_BRANCH;
          default: state_nxt = S_UNKNOWN;
        endcase
      end
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_MULEX:    state_nxt = mul_zero ? S_ALUWB : S_MULEX;
      S_MEMADR:   state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_nxt = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:    state_nxt = MemReady ? S_FETCH : S_MEMWR;
      S_BLINK:    state_nxt = S_BRANCH;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_FETCH;
    else
      state <= state_nxt;
  end

  // Remembers that the coming ALUWB writes back the multiplier result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mul_flag <= 1'b0;
    else if (state == S_FETCH)
      mul_flag <= 1'b0;
    else if (state == S_MULEX && mul_zero)
      mul_flag <= 1'b1;
  end

  assign mul_load = (state == S_DECODE) && (state_nxt == S_MULEX);
  assign mul_dec  = (state == S_MULEX);

  mc_down_counter #(.CNT_W(CNT_W)) u_mul_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (mul_load),
    .load_val (CNT_W'(MUL_LATENCY - 1)),
    .dec      (mul_dec),
    .count    (mul_cnt),
    .zero     (mul_zero)
  );

  // Enables are gated by reset so nothing reaches memory or the register file while it is held.
  always_comb begin
    MemReq    = 1'b0;
    MemW      = 1'b0;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    MulStart  = 1'b0;
    LinkW     = 1'b0;
    Illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        IRWrite   = MemReady;
        NextPC    = MemReady;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_EXECUTER: ALUOp = 1'b1;
      S_EXECUTEI: begin
        ALUOp   = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MULEX:  MulStart = (mul_cnt == CNT_W'(MUL_LATENCY - 1));
      S_ALUWB: begin
        RegW      = 1'b1;
        ResultSrc = mul_flag ? RES_MUL : RES_ALUOUT;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWR: begin
        MemReq = 1'b1;
        MemW   = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        RegW      = 1'b1;
        ResultSrc = RES_DATA;
      end
      S_BLINK: begin
        RegW      = 1'b1;
        LinkW     = 1'b1;
        ResultSrc = RES_ALURES;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_ZERO;
      end
      S_BRANCH: begin
        Branch    = 1'b1;
        ResultSrc = RES_ALURES;
        ALUSrcA   = SRCA_ALT;
        ALUSrcB   = SRCB_IMM;
      end
      S_UNKNOWN: Illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      MemReq    = 1'b0;
      MemW      = 1'b0;
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      Branch    = 1'b0;
      MulStart  = 1'b0;
      LinkW     = 1'b0;
      Illegal   = 1'b0;
      ALUOp     = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_FOUR;
      ResultSrc = RES_ALURES;
    end
  end

  assign StateDbg = state;

endmodule

// File: tb/tb_mainfsm_mc.sv
// Scoreboard bench for mainfsm_mc: directed instruction sequences, per-cycle expected outputs.
module tb_mainfsm_mc;

  localparam int ML = 3;

  localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MB = 4'd4, MW = 4'd5,
                         XR = 4'd6, XI = 4'd7, AW = 4'd8, BR = 4'd9, UK = 4'd10, MX = 4'd11,
                         BL = 4'd12;

  typedef struct packed {
    logic [3:0] st;
    logic memreq, memw, irwrite, nextpc, regw, branch, aluop, adrsrc, mulstart, linkw, illegal;
    logic [1:0] srca, srcb, res;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = '0;
  logic [5:0] Funct = '0;
  logic       IsMul = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, MemW, IRWrite, NextPC, RegW, Branch, ALUOp, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic       MulStart, LinkW, Illegal;
  logic [3:0] StateDbg;

  int    checks = 0;
  int    errors = 0;
  obs_t  sb[$];
  string tags[$];
  obs_t  mon_e, mon_a;
  string mon_t;

  mainfsm_mc #(.MUL_LATENCY(ML)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .IsMul(IsMul), .MemReady(MemReady),
    .MemReq(MemReq), .MemW(MemW), .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW),
    .Branch(Branch), .ALUOp(ALUOp), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .MulStart(MulStart), .LinkW(LinkW), .Illegal(Illegal),
    .StateDbg(StateDbg)
  );

  always #5 clk = ~clk;

  function automatic obs_t exp_out(logic [3:0] st, logic rdy, logic first, logic mres, logic rst);
    obs_t o;
    o = '0;
    o.st = st;
    case (st)
      FE: begin o.memreq = 1; o.res = 2'b10; o.srca = 2'b01; o.srcb = 2'b10;
                o.irwrite = rdy; o.nextpc = rdy; end
      DE: begin o.res = 2'b10; o.srca = 2'b01; o.srcb = 2'b10; end
      XR: o.aluop = 1;
      XI: begin o.aluop = 1; o.srcb = 2'b01; end
      MX: o.mulstart = first;
      AW: begin o.regw = 1; o.res = mres ? 2'b11 : 2'b00; end
      MA: o.srcb = 2'b01;
      MR: begin o.memreq = 1; o.adrsrc = 1; end
      MW: begin o.memreq = 1; o.memw = 1; o.adrsrc = 1; end
      MB: begin o.regw = 1; o.res = 2'b01; end
      BL: begin o.regw = 1; o.linkw = 1; o.res = 2'b10; o.srca = 2'b01; o.srcb = 2'b11; end
      BR: begin o.branch = 1; o.res = 2'b10; o.srca = 2'b10; o.srcb = 2'b01; end
      UK: o.illegal = 1;
      default: ;
    endcase
    if (rst) begin
      o = '0;
      o.res = 2'b10; o.srca = 2'b01; o.srcb = 2'b10;
    end
    return o;
  endfunction

  // Called just after a rising edge: drives this cycle's inputs and queues what the DUT must show.
  task automatic cyc(input string tag, input logic [1:0] op, input logic [5:0] fn, input logic im,
                     input logic rdy, input logic [3:0] st, input logic first = 1'b0,
                     input logic mres = 1'b0);
    Op = op; Funct = fn; IsMul = im; MemReady = rdy;
    sb.push_back(exp_out(st, rdy, first, mres, reset));
    tags.push_back(tag);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      mon_t = tags.pop_front();
      mon_a = {StateDbg, MemReq, MemW, IRWrite, NextPC, RegW, Branch, ALUOp, AdrSrc,
               MulStart, LinkW, Illegal, ALUSrcA, ALUSrcB, ResultSrc};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s state got %0d want %0d outputs got %h want %h",
                 mon_t, mon_a.st, mon_e.st, mon_a, mon_e);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    cyc("reset", 2'b00, 6'h00, 0, 1, FE);
    reset = 1'b0;

    cyc("fwait0", 2'b00, 6'b000100, 0, 0, FE);
    cyc("fwait1", 2'b00, 6'b000100, 0, 0, FE);
    cyc("fwait2", 2'b00, 6'b000100, 0, 0, FE);
    cyc("fready", 2'b00, 6'b000100, 0, 1, FE);
    cyc("add_de", 2'b00, 6'b000100, 0, 1, DE);
    cyc("add_ex", 2'b00, 6'b000100, 0, 1, XR);
    cyc("add_wb", 2'b00, 6'b000100, 0, 1, AW);

    cyc("addi_fe", 2'b00, 6'b100100, 0, 1, FE);
    cyc("addi_de", 2'b00, 6'b100100, 0, 1, DE);
    cyc("addi_ex", 2'b00, 6'b100100, 0, 1, XI);
    cyc("addi_wb", 2'b00, 6'b100100, 0, 1, AW);

    cyc("ldr_fe",  2'b01, 6'b011001, 0, 1, FE);
    cyc("ldr_de",  2'b01, 6'b011001, 0, 0, DE);
    cyc("ldr_ma",  2'b01, 6'b011001, 0, 1, MA);
    cyc("ldr_rd0", 2'b01, 6'b011001, 0, 0, MR);
    cyc("ldr_rd1", 2'b01, 6'b011001, 0, 0, MR);
    cyc("ldr_rd2", 2'b01, 6'b011001, 0, 1, MR);
    cyc("ldr_wb",  2'b01, 6'b011001, 0, 1, MB);

    cyc("str_fe",  2'b01, 6'b011000, 0, 1, FE);
    cyc("str_de",  2'b01, 6'b011000, 0, 0, DE);
    cyc("str_ma",  2'b01, 6'b011000, 0, 0, MA);
    cyc("str_wr0", 2'b01, 6'b011000, 0, 0, MW);
    cyc("str_wr1", 2'b01, 6'b011000, 0, 1, MW);

    cyc("mul_fe",  2'b00, 6'b000000, 1, 1, FE);
    cyc("mul_de",  2'b00, 6'b000000, 1, 1, DE);
    cyc("mul_x0",  2'b00, 6'b000000, 1, 1, MX, 1'b1);
    cyc("mul_x1",  2'b00, 6'b000000, 1, 1, MX);
    cyc("mul_x2",  2'b00, 6'b000000, 1, 1, MX);
    cyc("mul_wb",  2'b00, 6'b000000, 1, 1, AW, 1'b0, 1'b1);
    cyc("add2_fe", 2'b00, 6'b000100, 0, 1, FE);
    cyc("add2_de", 2'b00, 6'b000100, 0, 1, DE);
    cyc("add2_ex", 2'b00, 6'b000100, 0, 1, XR);
    cyc("add2_wb", 2'b00, 6'b000100, 0, 1, AW);

    cyc("b_fe",  2'b10, 6'b100000, 0, 1, FE);
    cyc("b_de",  2'b10, 6'b100000, 0, 1, DE);
    cyc("b_br",  2'b10, 6'b100000, 0, 1, BR);

    cyc("bl_fe", 2'b10, 6'b010000, 0, 1, FE);
    cyc("bl_de", 2'b10, 6'b010000, 0, 1, DE);
    cyc("bl_lk", 2'b10, 6'b010000, 0, 1, BL);
    cyc("bl_br", 2'b10, 6'b010000, 0, 1, BR);

    cyc("und_fe", 2'b11, 6'b000000, 0, 1, FE);
    cyc("und_de", 2'b11, 6'b000000, 0, 1, DE);
    cyc("und_uk", 2'b11, 6'b000000, 0, 1, UK);

    cyc("rmul_fe", 2'b00, 6'b000000, 1, 1, FE);
    cyc("rmul_de", 2'b00, 6'b000000, 1, 1, DE);
    cyc("rmul_x0", 2'b00, 6'b000000, 1, 1, MX, 1'b1);
    reset = 1'b1;
    #1;
    checks++;
    if (StateDbg !== 4'd0 || MulStart !== 1'b0 || MemReq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got state %0d mulstart %b memreq %b want 0 0 0",
               StateDbg, MulStart, MemReq);
    end
    cyc("rmul_rst", 2'b00, 6'b000000, 1, 1, FE);
    reset = 1'b0;
    cyc("post_fe", 2'b00, 6'b000100, 0, 1, FE);
    cyc("post_de", 2'b00, 6'b000100, 0, 1, DE);
    cyc("post_ex", 2'b00, 6'b000100, 0, 1, XR);
    cyc("post_wb", 2'b00, 6'b000100, 0, 1, AW);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
